// File: rtl/plru_tracker.sv
// plru_tracker
// Per-set tree pseudo-LRU state for a set-associative cache.
//   - Each set holds a WAYS-1 bit tree in in-order layout. A subtree that covers
//     leaves [lo, lo+n) keeps its root at bit lo + n/2 - 1.
//   - A node bit of 1 means "victim is in the upper half".
//   - A hit (touch) makes every node on the way's path point away from it.
//   - Victim queries prefer the lowest invalid way. Otherwise they walk the tree.
//     With victim_alloc set, the chosen way is made MRU in the same cycle.
//   - After reset or flush, a sweep clears one set per cycle. busy is high during
//     the sweep.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   flush               - restart the clear sweep (IDLE only)
//   touch_valid/set/way - hit update
//   victim_req/set/valid_mask/alloc - victim query (result one cycle later)
//   busy                - sweep in progress, requests dropped
//   victim_valid/way    - registered victim result; way holds when not valid
module plru_tracker #(
    parameter int WAYS     = 4,
    parameter int LOG_WAYS = 2,
    parameter int SETS     = 16,
    parameter int LOG_SETS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                touch_valid,
    input  logic [LOG_SETS-1:0] touch_set,
    input  logic [LOG_WAYS-1:0] touch_way,
    input  logic                victim_req,
    input  logic [LOG_SETS-1:0] victim_set,
    input  logic [WAYS-1:0]     victim_valid_mask,
    input  logic                victim_alloc,
    output logic                busy,
    output logic                victim_valid,
    output logic [LOG_WAYS-1:0] victim_way
);

    localparam int TW = WAYS - 1;

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t              state_reg, state_next;
    logic [LOG_SETS-1:0] init_cnt_reg, init_cnt_next;
    logic                victim_valid_reg, victim_valid_next;
    logic [LOG_WAYS-1:0] victim_way_reg, victim_way_next;

    logic [TW-1:0]       tree_rd [SETS];
    logic                accept;
    logic                touch_en;
    logic                victim_en;
    logic                alloc_en;
    logic [LOG_WAYS-1:0] victim_sel;

    // Point every node on way w's path away from w.
    function automatic logic [TW-1:0] touch_tree(input logic [TW-1:0] t,
                                                 input logic [LOG_WAYS-1:0] w);
        logic [TW-1:0]       r;
        logic [LOG_WAYS-1:0] idx;
        int                  n;
        int                  b;
        r = t;
        for (int d = 0; d < LOG_WAYS; d++) begin
            n   = WAYS >> d;
            idx = LOG_WAYS'((int'(w) & ~(n - 1)) + n / 2 - 1);
            b   = (int'(w) >> (LOG_WAYS - 1 - d)) & 1;
            r[idx] = (b == 0);
        end
        return r;
    endfunction

    // Lowest invalid way wins. With a full mask, follow the node bits from the root.
    function automatic logic [LOG_WAYS-1:0] pick_victim(input logic [TW-1:0] t,
                                                        input logic [WAYS-1:0] m);
        logic                found;
        logic [LOG_WAYS-1:0] v;
        logic [LOG_WAYS-1:0] lo;
        logic [LOG_WAYS-1:0] idx;
        int                  half;
        found = 1'b0;
        v     = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (!found && (((m >> i) & WAYS'(1)) == WAYS'(0))) begin
                found = 1'b1;
                v     = LOG_WAYS'(i);
            end
        end
        if (!found) begin
            lo = '0;
            for (int d = 0; d < LOG_WAYS; d++) begin
                half = (WAYS >> d) / 2;
                idx  = LOG_WAYS'(int'(lo) + half - 1);
                if (t[idx]) begin
                    lo = lo + LOG_WAYS'(half);
                end
            end
            v = lo;
        end
        return v;
    endfunction

    // Requests are taken only in IDLE, and never in a flush or reset cycle.
    assign accept     = (state_reg == ST_IDLE) && !flush && !reset;
    assign touch_en   = accept && touch_valid;
    assign victim_en  = accept && victim_req;
    assign alloc_en   = victim_en && victim_alloc;
    // The victim is chosen from the tree as it stood before this edge.
    assign victim_sel = pick_victim(tree_rd[victim_set], victim_valid_mask);

    for (genvar gi = 0; gi < SETS; gi++) begin : g_set
        logic [TW-1:0] tree_reg, tree_next;

        // A touch is applied first and an alloc touch second. When both hit the
        // same set, the allocated victim therefore ends up MRU.
        always_comb begin
            tree_next = tree_reg;
            if (state_reg == ST_INIT) begin
                if (init_cnt_reg == LOG_SETS'(gi)) begin
                    tree_next = '0;
                end
            end else begin
                if (touch_en && (touch_set == LOG_SETS'(gi))) begin
                    tree_next = touch_tree(tree_next, touch_way);
                end
                if (alloc_en && (victim_set == LOG_SETS'(gi))) begin
                    tree_next = touch_tree(tree_next, victim_sel);
                end
            end
        end

        // Tree contents need no reset: the sweep clears every set.
        always_ff @(posedge clk) begin
            tree_reg <= tree_next;
        end

        assign tree_rd[gi] = tree_reg;
    end

    always_comb begin
        state_next        = state_reg;
        init_cnt_next     = init_cnt_reg;
        victim_valid_next = victim_en;
        victim_way_next   = victim_en ? victim_sel : victim_way_reg;
        case (state_reg)
            ST_INIT: begin
                init_cnt_next = init_cnt_reg + LOG_SETS'(1);
                if (init_cnt_reg == LOG_SETS'(SETS - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (flush) begin
                    state_next    = ST_INIT;
                    init_cnt_next = '0;
                end
            end
            default: begin
                state_next    = ST_INIT;
                init_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_INIT;
            init_cnt_reg     <= '0;
            victim_valid_reg <= 1'b0;
            victim_way_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            init_cnt_reg     <= init_cnt_next;
            victim_valid_reg <= victim_valid_next;
            victim_way_reg   <= victim_way_next;
        end
    end

    assign busy         = (state_reg == ST_INIT);
    assign victim_valid = victim_valid_reg;
    assign victim_way   = victim_way_reg;

endmodule

// File: tb/tb_plru_tracker.sv
// Testbench for plru_tracker.
// The main instance is WAYS=4, SETS=4. Three more instances use WAYS=2/8/16.
// The reference model keeps one "victim direction" bit per tree node, keyed by
// heap position (depth, path prefix).
module tb_plru_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       touch_valid = 1'b0;
    logic [1:0] touch_set = '0;
    logic [1:0] touch_way = '0;
    logic       victim_req = 1'b0;
    logic [1:0] victim_set = '0;
    logic [3:0] victim_valid_mask = 4'hF;
    logic       victim_alloc = 1'b0;
    logic       busy;
    logic       victim_valid;
    logic [1:0] victim_way;

    logic [2:0]  p_tv = '0;
    logic [2:0]  p_vr = '0;
    logic [3:0]  p_tw [3] = '{default: '0};
    logic [15:0] p_mask [3] = '{default: 16'hFFFF};
    logic [2:0]  p_busy;
    logic [2:0]  p_vv;
    logic [3:0]  p_vway [3];

    int checks = 0;
    int failures = 0;

    // Model state: cfg 0 is the main DUT, cfg 1..3 are the parameter instances.
    bit m_dir [4][4][32];

    always #5 clk = ~clk;

    plru_tracker #(.WAYS(4), .LOG_WAYS(2), .SETS(4), .LOG_SETS(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way),
        .victim_req(victim_req), .victim_set(victim_set),
        .victim_valid_mask(victim_valid_mask), .victim_alloc(victim_alloc),
        .busy(busy), .victim_valid(victim_valid), .victim_way(victim_way)
    );

    for (genvar gk = 0; gk < 3; gk++) begin : g_cfg
        localparam int LW = (gk == 0) ? 1 : (gk == 1) ? 3 : 4;
        localparam int W  = 1 << LW;
        logic [LW-1:0] vw;
        plru_tracker #(.WAYS(W), .LOG_WAYS(LW), .SETS(4), .LOG_SETS(2)) u_p (
            .clk(clk), .reset(reset), .flush(flush),
            .touch_valid(p_tv[gk]), .touch_set(touch_set), .touch_way(p_tw[gk][LW-1:0]),
            .victim_req(p_vr[gk]), .victim_set(victim_set),
            .victim_valid_mask(p_mask[gk][W-1:0]), .victim_alloc(1'b0),
            .busy(p_busy[gk]), .victim_valid(p_vv[gk]), .victim_way(vw)
        );
        assign p_vway[gk] = 4'(vw);
    end

    // ---------------- reference model ----------------
    function automatic void m_clear();
        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 4; s++)
                for (int k = 0; k < 32; k++)
                    m_dir[c][s][k] = 1'b0;
    endfunction

    // A touch makes every ancestor of leaf w point to the other child.
    function automatic void m_touch(int c, int s, int w, int lw);
        for (int d = 0; d < lw; d++) begin
            int key;
            key = (1 << d) | (w >> (lw - d));
            m_dir[c][s][key] = (((w >> (lw - 1 - d)) & 1) == 0);
        end
    endfunction

    function automatic int m_victim(int c, int s, int mask, int lw);
        int p;
        for (int i = 0; i < (1 << lw); i++)
            if (((mask >> i) & 1) == 0) return i;
        p = 0;
        for (int d = 0; d < lw; d++)
            p = (p << 1) | int'(m_dir[c][s][(1 << d) | p]);
        return p;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_touch(int s, int w);
        touch_valid = 1'b1;
        touch_set   = 2'(s);
        touch_way   = 2'(w);
        step();
        touch_valid = 1'b0;
        m_touch(0, s, w, 2);
    endtask

    task automatic do_query(int s, logic [3:0] mask, output logic vv, output logic [1:0] vw);
        victim_req        = 1'b1;
        victim_set        = 2'(s);
        victim_valid_mask = mask;
        victim_alloc      = 1'b0;
        step();
        victim_req        = 1'b0;
        victim_valid_mask = 4'hF;
        vv = victim_valid;
        vw = victim_way;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic vv;
        logic [1:0] vw;
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1 || victim_valid !== 1'b0 || victim_way !== 2'd0) begin
            failures++;
            $display("FAIL reset_values busy=%0b vv=%0b way=%0d exp 1/0/0", busy, victim_valid, victim_way);
        end
        step();
        reset = 1'b0;
        m_clear();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL sweep_busy cycle=%0d got=%0b exp=1", i, busy);
            end
            step();
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL sweep_end got=%0b exp=0", busy);
        end
        do_query(2, 4'hF, vv, vw);
        checks++;
        if (vv !== 1'b1 || vw !== 2'd0) begin
            failures++;
            $display("FAIL reset_query vv=%0b way=%0d exp vv=1 way=0", vv, vw);
        end
        $display("test_reset: query set2 -> way %0d", vw);
    endtask

    task automatic test_touch_seq();
        logic vv;
        logic [1:0] vw;
        int exp_w [3] = '{0, 2, 1};
        for (int w = 0; w < 4; w++) do_touch(1, w);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) do_touch(1, 0);
            if (k == 2) do_touch(1, 2);
            do_query(1, 4'hF, vv, vw);
            checks++;
            if (vv !== 1'b1 || int'(vw) != exp_w[k]) begin
                failures++;
                $display("FAIL touch_seq step=%0d vv=%0b way=%0d exp way=%0d", k, vv, vw, exp_w[k]);
            end
            $display("test_touch_seq: step %0d victim %0d", k, vw);
        end
    endtask

    task automatic test_invalid_pref();
        logic vv;
        logic [1:0] vw;
        logic [3:0] masks [3] = '{4'b1011, 4'b0110, 4'b1111};
        int exp_w [3] = '{2, 0, 2};
        do_touch(0, 0);
        for (int k = 0; k < 3; k++) begin
            do_query(0, masks[k], vv, vw);
            checks++;
            if (vv !== 1'b1 || int'(vw) != exp_w[k]) begin
                failures++;
                $display("FAIL invalid_pref mask=%b vv=%0b way=%0d exp way=%0d", masks[k], vv, vw, exp_w[k]);
            end
            $display("test_invalid_pref: mask %b victim %0d", masks[k], vw);
        end
    endtask

    task automatic test_alloc_collision();
        logic vv;
        logic [1:0] vw;
        touch_valid = 1'b1; touch_set = 2'd3; touch_way = 2'd1;
        victim_req = 1'b1; victim_set = 2'd3; victim_valid_mask = 4'hF; victim_alloc = 1'b1;
        step();
        touch_valid = 1'b0; victim_req = 1'b0; victim_alloc = 1'b0;
        m_touch(0, 3, 1, 2);
        m_touch(0, 3, 0, 2);
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd0) begin
            failures++;
            $display("FAIL alloc_victim vv=%0b way=%0d exp vv=1 way=0", victim_valid, victim_way);
        end
        do_query(3, 4'hF, vv, vw);
        checks++;
        if (vv !== 1'b1 || vw !== 2'd2) begin
            failures++;
            $display("FAIL alloc_after vv=%0b way=%0d exp way=2", vv, vw);
        end
        $display("test_alloc_collision: next victim %0d", vw);
    endtask

    task automatic test_back_to_back();
        victim_req = 1'b1; victim_alloc = 1'b0;
        victim_set = 2'd2; victim_valid_mask = 4'b1110;
        step();
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd0) begin
            failures++;
            $display("FAIL b2b_first vv=%0b way=%0d exp vv=1 way=0", victim_valid, victim_way);
        end
        victim_set = 2'd0; victim_valid_mask = 4'b1011;
        step();
        victim_req = 1'b0; victim_valid_mask = 4'hF;
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd2) begin
            failures++;
            $display("FAIL b2b_second vv=%0b way=%0d exp vv=1 way=2", victim_valid, victim_way);
        end
        step();
        checks++;
        if (victim_valid !== 1'b0 || victim_way !== 2'd2) begin
            failures++;
            $display("FAIL b2b_hold vv=%0b way=%0d exp vv=0 way=2", victim_valid, victim_way);
        end
        $display("test_back_to_back: held way %0d", victim_way);
    endtask

    task automatic test_random();
        int n_err = 0;
        for (int i = 0; i < 300; i++) begin
            int tv, ts, tw, vr, vs, va, mk, exp_v;
            tv = $urandom_range(0, 1);
            ts = $urandom_range(0, 3);
            tw = $urandom_range(0, 3);
            vr = $urandom_range(0, 1);
            vs = $urandom_range(0, 3);
            va = $urandom_range(0, 1);
            mk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 15;
            touch_valid = tv[0]; touch_set = 2'(ts); touch_way = 2'(tw);
            victim_req = vr[0]; victim_set = 2'(vs); victim_alloc = va[0];
            victim_valid_mask = 4'(mk);
            exp_v = m_victim(0, vs, mk, 2);
            if (tv != 0) m_touch(0, ts, tw, 2);
            if (vr != 0 && va != 0) m_touch(0, vs, exp_v, 2);
            step();
            checks++;
            if (victim_valid !== vr[0] || (vr != 0 && int'(victim_way) != exp_v)) begin
                failures++;
                n_err++;
                $display("FAIL random cyc=%0d vv=%0b way=%0d exp vv=%0d way=%0d", i, victim_valid, victim_way, vr, exp_v);
            end
        end
        touch_valid = 1'b0; victim_req = 1'b0; victim_alloc = 1'b0; victim_valid_mask = 4'hF;
        $display("test_random: 300 cycles, %0d errors", n_err);
    endtask

    task automatic test_flush_reset();
        logic vv;
        logic [1:0] vw;
        flush = 1'b1; touch_valid = 1'b1; touch_set = 2'd1; touch_way = 2'd3;
        victim_req = 1'b1; victim_set = 2'd1; victim_valid_mask = 4'hF;
        step();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b1 || victim_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle busy=%0b vv=%0b exp 1/0", busy, victim_valid);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_clear();
        for (int i = 0; i < 4; i++) begin
            touch_way = 2'($urandom_range(0, 3));
            touch_set = 2'($urandom_range(0, 3));
            checks++;
            if (busy !== 1'b1 || victim_valid !== 1'b0) begin
                failures++;
                $display("FAIL busy_drop cycle=%0d busy=%0b vv=%0b exp 1/0", i, busy, victim_valid);
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || victim_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_end busy=%0b vv=%0b exp 0/0", busy, victim_valid);
        end
        touch_valid = 1'b0; victim_req = 1'b0;
        for (int s = 0; s < 4; s++) begin
            do_query(s, 4'hF, vv, vw);
            checks++;
            if (vv !== 1'b1 || vw !== 2'd0) begin
                failures++;
                $display("FAIL cleared set=%0d vv=%0b way=%0d exp way=0", s, vv, vw);
            end
        end
        $display("test_flush_reset: all sets cleared");
    endtask

    task automatic test_param_sweep();
        int lws [3] = '{1, 3, 4};
        for (int k = 0; k < 3; k++) begin
            int lw, w_n, exp_v;
            logic [15:0] full;
            lw = lws[k];
            w_n = 1 << lw;
            full = (w_n == 16) ? 16'hFFFF : 16'((1 << w_n) - 1);
            for (int r = 0; r < 2 + ((k == 0) ? 1 : 0); r++) begin
                if (r == 0) begin
                    for (int w = 0; w < w_n; w++) begin
                        p_tv[k] = 1'b1; touch_set = 2'd1; p_tw[k] = 4'(w);
                        step();
                        p_tv[k] = 1'b0;
                        m_touch(k + 1, 1, w, lw);
                    end
                    exp_v = 0;
                end else if (r == 1) begin
                    for (int j = 0; j < 40; j++) begin
                        int w;
                        w = $urandom_range(0, w_n - 1);
                        p_tv[k] = 1'b1; touch_set = 2'd2; p_tw[k] = 4'(w);
                        step();
                        p_tv[k] = 1'b0;
                        m_touch(k + 1, 2, w, lw);
                    end
                    exp_v = m_victim(k + 1, 2, int'(full), lw);
                end else begin
                    p_tv[k] = 1'b1; touch_set = 2'd3; p_tw[k] = 4'd0;
                    step();
                    p_tv[k] = 1'b0;
                    m_touch(k + 1, 3, 0, lw);
                    exp_v = 1;
                end
                p_vr[k] = 1'b1; victim_set = 2'(r + 1); p_mask[k] = full;
                step();
                p_vr[k] = 1'b0;
                checks++;
                if (p_vv[k] !== 1'b1 || int'(p_vway[k]) != exp_v) begin
                    failures++;
                    $display("FAIL param ways=%0d run=%0d vv=%0b way=%0d exp way=%0d", w_n, r, p_vv[k], p_vway[k], exp_v);
                end
                $display("test_param_sweep: ways=%0d run=%0d victim %0d", w_n, r, p_vway[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_touch_seq();
        test_invalid_pref();
        test_alloc_collision();
        test_back_to_back();
        test_random();
        test_flush_reset();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
